csi2tx_raw6_b2p: RTL and testbench

RAW6 byte-to-pixel unpacker, the inverse of the RAW6 pixel-to-byte packer. It takes 32-bit packed payload words from the long-packet datapath and emits one 6-bit pixel per handshake. It sits in the loopback/checker path, between the payload word stream and the pixel-side compare/sink logic. Line length comes from the packet word count, latched at line start; padding bits in the final word are discarded.

---
 rtl/csi2tx_raw6_b2p.sv | 104 ++++++++++
 tb/tb_csi2tx_raw6_b2p.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/csi2tx_raw6_b2p.sv
// RAW6 byte-to-pixel unpacker: 32-bit LSB-first payload words in, one 6-bit pixel per handshake out.
// Line length is taken from the word count at line_start; padding and remainder bits are dropped at line end.
module csi2tx_raw6_b2p #(
  parameter int WC_W  = 16,
  parameter int BUF_W = 44
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            raw6_convrn_enable,
  input  logic            line_start,
  input  logic [WC_W-1:0] line_wc,
  input  logic [31:0]     dw,
  input  logic            dw_vld,
  output logic            dw_rdy,
  output logic [5:0]      pixel_data,
  output logic            pixel_vld,
  input  logic            pixel_rdy,
  output logic            pixel_last,
  output logic            line_done,
  output logic            wc_err
);

  localparam int CNT_W = $clog2(BUF_W + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [BUF_W-1:0] buffer;
  logic [CNT_W-1:0] bit_cnt;
  logic [WC_W:0]    pix_left;
  logic [WC_W-1:0]  words_left;

  logic             accept;
  logic             pop;
  logic [BUF_W-1:0] buf_shift;
  logic [BUF_W-1:0] word_ins;
  logic [CNT_W-1:0] cnt_shift;
  logic [WC_W+1:0]  wc_x4;
  logic [WC_W:0]    wc_plus3;

  assign dw_rdy     = (state == ACTIVE) && (words_left != '0) && (bit_cnt <= CNT_W'(11));
  assign pixel_vld  = (state == ACTIVE) && (bit_cnt >= CNT_W'(6)) && (pix_left != '0);
  assign pixel_data = buffer[5:0];
  assign pixel_last = pixel_vld && (pix_left == (WC_W+1)'(1));

  assign accept   = dw_vld && dw_rdy;
  assign pop      = pixel_vld && pixel_rdy;
  assign wc_x4    = {line_wc, 2'b00};
  assign wc_plus3 = {1'b0, line_wc} + (WC_W+1)'(3);

  // A same-cycle pop shifts first, so the incoming word lands at bit_cnt-6.
  always_comb begin
    buf_shift = pop ? (buffer >> 6) : buffer;
    cnt_shift = pop ? (bit_cnt - CNT_W'(6)) : bit_cnt;
    word_ins  = BUF_W'(dw) << cnt_shift;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !raw6_convrn_enable) begin
      state      <= IDLE;
      buffer     <= '0;
      bit_cnt    <= '0;
      pix_left   <= '0;
      words_left <= '0;
      line_done  <= 1'b0;
      wc_err     <= 1'b0;
    end else begin
      line_done <= 1'b0;
      wc_err    <= 1'b0;
      if (line_start) begin
        buffer     <= '0;
        bit_cnt    <= '0;
        pix_left   <= (WC_W+1)'(wc_x4 / (WC_W+2)'(3));
        words_left <= {1'b0, wc_plus3[WC_W:2]};
        wc_err     <= (line_wc % WC_W'(3)) != '0;
        if (line_wc == '0) begin
          state     <= IDLE;
          line_done <= 1'b1;
        end else begin
          state <= ACTIVE;
        end
      end else if (state == ACTIVE) begin
        if (pop && pixel_last) begin
          state      <= IDLE;
          buffer     <= '0;
          bit_cnt    <= '0;
          pix_left   <= '0;
          words_left <= '0;
          line_done  <= 1'b1;
        end else begin
          buffer  <= accept ? (buf_shift | word_ins) : buf_shift;
          bit_cnt <= accept ? (cnt_shift + CNT_W'(32)) : cnt_shift;
          if (accept) words_left <= words_left - WC_W'(1);
          if (pop)    pix_left   <= pix_left - (WC_W+1)'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  bit_cnt_max: assert property (@(posedge clk) bit_cnt <= CNT_W'(BUF_W - 1));
`endif

endmodule

// File: tb/tb_csi2tx_raw6_b2p.sv
// Randomised bench for csi2tx_raw6_b2p; pixels are predicted by slicing the raw word bit stream.
module tb_csi2tx_raw6_b2p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        raw6_convrn_enable;
  logic        line_start;
  logic [15:0] line_wc;
  logic [31:0] dw;
  logic        dw_vld;
  logic        dw_rdy;
  logic [5:0]  pixel_data;
  logic        pixel_vld;
  logic        pixel_rdy;
  logic        pixel_last;
  logic        line_done;
  logic        wc_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] words[$];

  always #5 clk = ~clk;

  csi2tx_raw6_b2p #(.WC_W(16), .BUF_W(44)) dut (
    .clk(clk), .rst_n(rst_n), .raw6_convrn_enable(raw6_convrn_enable),
    .line_start(line_start), .line_wc(line_wc),
    .dw(dw), .dw_vld(dw_vld), .dw_rdy(dw_rdy),
    .pixel_data(pixel_data), .pixel_vld(pixel_vld), .pixel_rdy(pixel_rdy),
    .pixel_last(pixel_last), .line_done(line_done), .wc_err(wc_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pixel n is simply stream bits [6n+5:6n], words concatenated LSB-first.
  function automatic logic [5:0] ref_pix(input int n);
    logic [5:0]  p;
    logic [31:0] w;
    for (int b = 0; b < 6; b++) begin
      w    = words[(6*n + b) / 32];
      p[b] = w[(6*n + b) % 32];
    end
    return p;
  endfunction

  task automatic fill_random(input int wc);
    words.delete();
    for (int i = 0; i < (wc + 3) / 4; i++) words.push_back($urandom);
  endtask

  // Called at a negedge; returns at the negedge after line_start was sampled.
  task automatic start_line(input int wc);
    line_start = 1'b1;
    line_wc    = 16'(wc);
    dw_vld     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    line_start = 1'b0;
    #1;
    check("wc_err", wc_err, (wc % 3) != 0);
    if (wc == 0) begin
      check("wc0_done", line_done, 1);
      check("wc0_rdy", dw_rdy, 0);
    end
  endtask

  // rdy_mode: 0 = always ready, 1 = toggle every cycle, 2 = random.
  task automatic run_line(input int wc, input int rdy_mode, input bit rand_vld, input bit tput);
    int np, nexp, idx, nw, cyc, first, last;
    bit held;
    logic [5:0] hold_val;
    np = wc * 4 / 3;
    nexp = (wc + 3) / 4;
    idx = 0; nw = 0; cyc = 0; first = -1; last = -1; held = 0; hold_val = '0;
    start_line(wc);
    if (wc == 0) return;
    while (idx < np && cyc < 500) begin
      dw_vld    = rand_vld ? 1'($urandom_range(0, 1)) : 1'b1;
      dw        = (nw < words.size()) ? words[nw] : $urandom;
      pixel_rdy = (rdy_mode == 0) ? 1'b1 :
                  (rdy_mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      #1;
      if (held) begin
        check("hold_vld", pixel_vld, 1);
        check("hold_dat", pixel_data, hold_val);
      end
      check("done_early", line_done, 0);
      if (pixel_vld && pixel_rdy) begin
        check($sformatf("pix%0d", idx), pixel_data, ref_pix(idx));
        check("last", pixel_last, idx == np - 1);
        if (first < 0) first = cyc;
        last = cyc;
        idx++;
      end
      if (dw_vld && dw_rdy) nw++;
      held     = pixel_vld && !pixel_rdy;
      hold_val = pixel_data;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("pix_count", idx, np);
    dw_vld = 1'b0;
    #1;
    check("line_done", line_done, 1);
    check("idle_vld", pixel_vld, 0);
    check("idle_rdy", dw_rdy, 0);
    check("words_acc", nw, nexp);
    if (tput) begin
      check("latency", first, 1);
      check("tput", last - first, np - 1);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check("done_pulse", line_done, 0);
  endtask

  task automatic mid_line_clear(input bit use_rst);
    fill_random(12);
    start_line(12);
    dw_vld = 1'b1; pixel_rdy = 1'b1; dw = words[0];
    @(posedge clk); @(negedge clk);
    dw = words[1];
    @(posedge clk); @(negedge clk);
    if (use_rst) rst_n = 1'b0; else raw6_convrn_enable = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; raw6_convrn_enable = 1'b1;
    #1;
    check("clr_vld", pixel_vld, 0);
    check("clr_dat", pixel_data, 0);
    check("clr_last", pixel_last, 0);
    check("clr_rdy", dw_rdy, 0);
    check("clr_done", line_done, 0);
    check("clr_err", wc_err, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk); #1;
      check("clr_hold_rdy", dw_rdy, 0);
      check("clr_hold_vld", pixel_vld, 0);
      check("clr_hold_done", line_done, 0);
    end
    dw_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; raw6_convrn_enable = 1'b1; line_start = 1'b0; line_wc = '0;
    dw = '0; dw_vld = 1'b0; pixel_rdy = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    check("rst_vld", pixel_vld, 0);
    check("rst_dat", pixel_data, 0);
    check("rst_rdy", dw_rdy, 0);
    check("rst_done", line_done, 0);
    check("rst_err", wc_err, 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Reference line: pixels 0..15, full rate.
    words = '{32'h440C2040, 32'hA2481C61, 32'h3CE34C2C};
    run_line(12, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) check("ref_val", 32'(ref_pix(i)), i);

    // Same stream under backpressure and bursty input.
    run_line(12, 1, 1'b1, 1'b0);

    words = '{32'hFF000FC3};
    run_line(3, 0, 1'b0, 1'b0);

    fill_random(5);
    run_line(5, 2, 1'b1, 1'b0);

    run_line(0, 0, 1'b0, 1'b0);

    // Abort: one word of a first line, then restart.
    fill_random(12);
    start_line(12);
    dw_vld = 1'b1; pixel_rdy = 1'b0; dw = words[0];
    #1;
    check("abort_acc", dw_rdy, 1);
    @(posedge clk); @(negedge clk);
    dw_vld = 1'b0;
    fill_random(12);
    run_line(12, 2, 1'b1, 1'b0);

    mid_line_clear(1'b1);
    fill_random(12);
    run_line(12, 0, 1'b0, 1'b1);
    mid_line_clear(1'b0);
    fill_random(9);
    run_line(9, 2, 1'b1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int wc;
      wc = $urandom_range(1, 40);
      fill_random(wc);
      run_line(wc, 2, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
